// File: rtl/fft8_bfly_scheduler.sv
// Issue/writeback sequencer for one shared pipelined radix-2 butterfly running an
// 8-point DIT FFT in place (3 stages x 4 butterflies), with host load/start/ready handshakes.
module fft8_bfly_scheduler #(
   parameter int unsigned BF_LATENCY = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       write,
   input  logic       start,
   output logic       load_en,
   output logic       bf_valid,
   output logic [2:0] bf_addr_a,
   output logic [2:0] bf_addr_b,
   output logic [1:0] tw_idx,
   output logic [1:0] stage,
   output logic       wb_valid,
   output logic [2:0] wb_addr_a,
   output logic [2:0] wb_addr_b,
   output logic       busy,
   output logic       done,
   output logic       ready
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_e;

   state_e     state_q, state_d;
   logic       start_q;
   logic       run_req;
   logic [1:0] s_q, s_d;
   logic [1:0] k_q, k_d;
   logic [1:0] wbc_q, wbc_d;
   logic       bf_valid_q, bf_valid_d;
   logic [2:0] addr_a_q, addr_a_d;
   logic [2:0] addr_b_q, addr_b_d;
   logic [1:0] tw_q, tw_d;
   logic       load_en_q, load_en_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       ready_q, ready_d;

   logic       wbv_q [BF_LATENCY];
   logic [2:0] wba_q [BF_LATENCY];
   logic [2:0] wbb_q [BF_LATENCY];

   // Returns {addr_a, addr_b, tw_idx} for stage s, butterfly k.
   function automatic logic [7:0] bf_map(input logic [1:0] s, input logic [1:0] k);
      logic [2:0] span, grp, pos, a, b;
      logic [1:0] tw;
      span = 3'd1 << s;
      grp  = {1'b0, k} >> s;
      pos  = {1'b0, k} & (span - 3'd1);
      a    = (grp << (s + 2'd1)) + pos;
      b    = a + span;
      tw   = pos[1:0] << (2'd2 - s);
      return {a, b, tw};
   endfunction

   assign run_req = start & ~start_q;

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      k_d        = k_q;
      wbc_d      = wb_valid ? wbc_q + 2'd1 : wbc_q;
      bf_valid_d = 1'b0;
      load_en_d  = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ready_d    = ready_q;
      case (state_q)
         IDLE: begin
            if (write) begin
               load_en_d = 1'b1;
               ready_d   = 1'b0;
            end else if (run_req) begin
               state_d    = ISSUE;
               s_d        = 2'd0;
               k_d        = 2'd0;
               wbc_d      = 2'd0;
               bf_valid_d = 1'b1;
               busy_d     = 1'b1;
               ready_d    = 1'b0;
            end
         end
         ISSUE: begin
            if (k_q == 2'd3) begin
               state_d = DRAIN;
            end else begin
               k_d        = k_q + 2'd1;
               bf_valid_d = 1'b1;
            end
         end
         DRAIN: begin
            // The 4th writeback of the stage is visible now; next reads may start.
            if (wb_valid && wbc_q == 2'd3) begin
               if (s_q == 2'd2) begin
                  state_d = FIN;
                  s_d     = 2'd0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  ready_d = 1'b1;
               end else begin
                  state_d    = ISSUE;
                  s_d        = s_q + 2'd1;
                  k_d        = 2'd0;
                  bf_valid_d = 1'b1;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      {addr_a_d, addr_b_d, tw_d} = bf_valid_d ? bf_map(s_d, k_d) : '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         s_q        <= '0;
         k_q        <= '0;
         wbc_q      <= '0;
         bf_valid_q <= 1'b0;
         addr_a_q   <= '0;
         addr_b_q   <= '0;
         tw_q       <= '0;
         load_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b0;
         for (int unsigned i = 0; i < BF_LATENCY; i++) begin
            wbv_q[i] <= 1'b0;
            wba_q[i] <= '0;
            wbb_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         start_q    <= start;
         s_q        <= s_d;
         k_q        <= k_d;
         wbc_q      <= wbc_d;
         bf_valid_q <= bf_valid_d;
         addr_a_q   <= addr_a_d;
         addr_b_q   <= addr_b_d;
         tw_q       <= tw_d;
         load_en_q  <= load_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
         wbv_q[0]   <= bf_valid_q;
         wba_q[0]   <= addr_a_q;
         wbb_q[0]   <= addr_b_q;
         for (int unsigned i = 1; i < BF_LATENCY; i++) begin
            wbv_q[i] <= wbv_q[i-1];
            wba_q[i] <= wba_q[i-1];
            wbb_q[i] <= wbb_q[i-1];
         end
      end
   end

   assign load_en   = load_en_q;
   assign bf_valid  = bf_valid_q;
   assign bf_addr_a = addr_a_q;
   assign bf_addr_b = addr_b_q;
   assign tw_idx    = tw_q;
   assign stage     = s_q;
   assign wb_valid  = wbv_q[BF_LATENCY-1];
   assign wb_addr_a = wba_q[BF_LATENCY-1];
   assign wb_addr_b = wbb_q[BF_LATENCY-1];
   assign busy      = busy_q;
   assign done      = done_q;
   assign ready     = ready_q;

endmodule

// File: doc/fft8_bfly_scheduler.md
Name: fft8_bfly_scheduler

Overview:
- Sequences a single shared, pipelined radix-2 butterfly unit through the full 8-point DIT FFT: 3 stages × 4 butterflies.
- Inputs are held in a bit-reversed-order 8-entry complex working memory.
- Per butterfly it issues read addresses and a twiddle index, then tracks the butterfly pipeline to issue matching writeback addresses.
- It stalls between stages until the previous stage has fully drained, and reports completion to the host through load/start/ready handshakes.

Parameters:
- BF_LATENCY, 2: cycles from bf_valid issue to result available at the butterfly output; legal range 1..8.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- write  input  1  host load request; loads the 8 input samples into working memory.
- start  input  1  host run request; rising-edge detected.
- load_en  output  1  one-cycle pulse; working memory captures in0..in7 (bit-reversed placement).
- bf_valid  output  1  butterfly issue strobe.
- bf_addr_a  output  3  upper-leg read address.
- bf_addr_b  output  3  lower-leg read address.
- tw_idx  output  2  twiddle index k for W8^k.
- stage  output  2  current issue stage (0..2).
- wb_valid  output  1  writeback strobe; results are written in place.
- wb_addr_a  output  3  writeback address, upper leg.
- wb_addr_b  output  3  writeback address, lower leg.
- busy  output  1  high from the first issue cycle through the final writeback.
- done  output  1  one-cycle completion pulse.
- ready  output  1  result-valid level.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (CLK, RST).
- Reset value: all outputs 0; FSM in IDLE; stage/butterfly counters 0; writeback pipeline flushed; start edge register cleared.
- Start edge detect: start_q <= start; run_req = start & ~start_q.
- Start held high through reset counts as a new edge after reset release.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE, write=1: load_en=1 next cycle; ready cleared. Write has priority over run_req in the same cycle; that start edge is lost.
- IDLE, run_req (and write=0): go to ISSUE; ready cleared; stage=0, k=0.
- ISSUE: bf_valid=1 each cycle for k=0..3 (registered outputs, first issue the cycle after the run_req edge). After k=3, go to DRAIN.
- Issue addressing for stage s, butterfly k:
  - span = 1<<s; grp = k>>s; pos = k & (span-1)
  - bf_addr_a = grp*2*span + pos
  - bf_addr_b = bf_addr_a + span
  - tw_idx = pos << (2-s)
  - s=0: (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0
  - s=1: (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2
  - s=2: (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3
- Writeback tracking: a BF_LATENCY-deep shift pipeline carries {valid, addr_a, addr_b}. wb_valid and wb_addr_* equal the bf_* values issued exactly BF_LATENCY cycles earlier.
- DRAIN: bf_valid=0. Leave DRAIN in the cycle after the stage's 4th writeback:
  - if s<2: s+1, k=0, back to ISSUE (RAW hazard avoided: no next-stage read before the last write).
  - if s=2: go to FIN.
- FIN: done=1 for one cycle; ready=1 (held); busy=0; return to IDLE.
- ready stays high until the next load_en or accepted run_req.
- Latency: with the run_req edge at cycle 0, issues occupy cycles 1-4, then 4+L+1 .. 8+L, then 2(4+L)+1 .. 2(4+L)+4. The final wb is at cycle 3(4+L); done is at cycle 3(4+L)+1 (L=2 → 19).
- Ignored while busy: write and run_req (no load_en, no restart). start_q still tracks start.
- RST mid-run: all in-flight writebacks are dropped immediately (wb_valid=0 while RST is asserted); outputs return to reset values.
- Counters never wrap out of range: k is 0..3, s is 0..2. The illegal state encoding recovers to IDLE.

Test Plan:
- Reset then idle, L=2 → all outputs 0; no bf_valid/wb_valid for 20 cycles with start=0 and write=0.
- write pulse in IDLE → load_en=1 exactly 1 cycle later, for exactly 1 cycle. write at the same edge as a start rising edge → load_en only; no bf_valid follows.
- start rising edge, L=2 → bf_valid at cycles 1-4, 7-10, 13-16 with the address/tw sequences above; wb_valid at cycles 3-6, 9-12, 15-18 mirroring them; done pulse at 19; ready=1 from 19.
- Repeat with BF_LATENCY=1 and BF_LATENCY=5 → done at cycles 16 and 28 respectively. No stage-s+1 issue precedes the last stage-s writeback.
- start held high continuously (pattern: write, then start=1 forever) → exactly one run; no restart after done until start falls and rises again.
- RST asserted at cycle 8 of a run → outputs 0 asynchronously; with start still high after release, a fresh run begins at stage 0, k=0.
